race_ctrl: RTL and testbench

RACE_CTRL -- requirements
Module: race_ctrl

---
 rtl/race_pkg.sv | 20 ++
 rtl/race_player.sv | 87 ++++++++
 rtl/race_ctrl.sv | 173 +++++++++++++++++
 tb/tb_race_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared state encoding and parameter defaults for the race controller
package race_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RACE      = 2'd2,
    ST_DONE      = 2'd3
  } race_state_t;

  localparam int DEF_NUM_PLAYERS = 2;
  localparam int DEF_POS_W       = 11;
  localparam int DEF_TRACK_LEN   = 768;
  localparam int DEF_NUM_LIGHTS  = 3;
  localparam int DEF_LIGHT_TICKS = 60;
  localparam int DEF_MAX_SPEED   = 15;
  localparam int DEF_SPEED_W     = 4;
  localparam int DEF_DECAY_TICKS = 8;

endpackage

// File: rtl/race_player.sv
// rtl/race_player.sv - one racer: speed with idle decay, position, finish flag, false-start flag
module race_player
  import race_pkg::*;
#(
  parameter int POS_W       = DEF_POS_W,
  parameter int TRACK_LEN   = DEF_TRACK_LEN,
  parameter int SPEED_W     = DEF_SPEED_W,
  parameter int MAX_SPEED   = DEF_MAX_SPEED,
  parameter int DECAY_TICKS = DEF_DECAY_TICKS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               cd_active,
  input  logic               race_active,
  input  logic               tick,
  input  logic               accel,
  output logic [SPEED_W-1:0] speed,
  output logic [POS_W-1:0]   pos,
  output logic               finished,
  output logic               dq,
  output logic               finish_now
);

  localparam int DCNT_W = $clog2(DECAY_TICKS + 1);

  localparam logic [POS_W:0]     TRACK_EXT = (POS_W + 1)'(TRACK_LEN);
  localparam logic [POS_W-1:0]   TRACK_POS = POS_W'(TRACK_LEN);
  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAX_SPEED);
  localparam logic [DCNT_W-1:0]  DECAY_END = DCNT_W'(DECAY_TICKS);

  logic [DCNT_W-1:0] decay_cnt;
  logic [DCNT_W-1:0] decay_inc;
  logic [POS_W:0]    pos_sum;
  logic              running;
  logic              reach;

  assign running    = race_active && !dq && !finished;
  // One extra bit so the sum cannot wrap before the clamp compare.
  assign pos_sum    = (POS_W + 1)'(pos) + (POS_W + 1)'(speed);
  assign reach      = pos_sum >= TRACK_EXT;
  assign finish_now = running && tick && reach;
  assign decay_inc  = decay_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      speed     <= '0;
      pos       <= '0;
      finished  <= 1'b0;
      dq        <= 1'b0;
      decay_cnt <= '0;
    end else if (clr) begin
      speed     <= '0;
      pos       <= '0;
      finished  <= 1'b0;
      dq        <= 1'b0;
      decay_cnt <= '0;
    end else begin
      if (cd_active && accel) begin
        dq <= 1'b1;
      end
      if (running) begin
        // Position advances with the speed held before this cycle's accel.
        if (tick) begin
          pos      <= reach ? TRACK_POS : pos_sum[POS_W-1:0];
          finished <= reach;
        end
        if (accel) begin
          if (speed != SPEED_MAX) begin
            speed <= speed + 1'b1;
          end
          decay_cnt <= '0;
        end else if (tick) begin
          if (decay_inc == DECAY_END) begin
            decay_cnt <= '0;
            if (speed != '0) begin
              speed <= speed - 1'b1;
            end
          end else begin
            decay_cnt <= decay_inc;
          end
        end
      end
    end
  end

endmodule

// File: rtl/race_ctrl.sv
// rtl/race_ctrl.sv - race sequencer: start lights, per-player racers, winner latch and race timer
module race_ctrl
  import race_pkg::*;
#(
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int POS_W       = DEF_POS_W,
  parameter int TRACK_LEN   = DEF_TRACK_LEN,
  parameter int NUM_LIGHTS  = DEF_NUM_LIGHTS,
  parameter int LIGHT_TICKS = DEF_LIGHT_TICKS,
  parameter int MAX_SPEED   = DEF_MAX_SPEED,
  parameter int SPEED_W     = DEF_SPEED_W,
  parameter int DECAY_TICKS = DEF_DECAY_TICKS,
  localparam int WIN_W      = $clog2(NUM_PLAYERS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick,
  input  logic                           start,
  input  logic                           abort,
  input  logic [NUM_PLAYERS-1:0]         accel,
  output logic [1:0]                     state,
  output logic [NUM_LIGHTS-1:0]          lights,
  output logic                           go,
  output logic [NUM_PLAYERS*POS_W-1:0]   pos,
  output logic [NUM_PLAYERS*SPEED_W-1:0] speed,
  output logic [NUM_PLAYERS-1:0]         finished,
  output logic [NUM_PLAYERS-1:0]         dq,
  output logic                           winner_valid,
  output logic [WIN_W-1:0]               winner_id,
  output logic                           tie,
  output logic [15:0]                    race_time
);

  localparam int LCNT_W = $clog2(LIGHT_TICKS + 1);
  localparam logic [LCNT_W-1:0] LIGHT_END = LCNT_W'(LIGHT_TICKS);

  race_state_t state_q, state_d;

  logic [LCNT_W-1:0]      light_cnt;
  logic [LCNT_W-1:0]      light_inc;
  logic                   light_step;
  logic                   lights_full;
  logic                   do_clr;
  logic                   cd_active;
  logic                   race_active;
  logic [NUM_PLAYERS-1:0] cd_accel;
  logic [NUM_PLAYERS-1:0] fin_now;
  logic                   all_dq;
  logic                   all_done;
  logic                   multi_fin;
  logic [WIN_W-1:0]       first_idx;

  assign state       = state_q;
  assign cd_active   = state_q == ST_COUNTDOWN;
  assign race_active = state_q == ST_RACE;
  assign do_clr      = abort || (start && (state_q == ST_IDLE || state_q == ST_DONE));
  assign light_inc   = light_cnt + 1'b1;
  assign light_step  = cd_active && tick && (light_inc == LIGHT_END);
  assign lights_full = &lights;

  // Judge with this cycle's effects folded in so DONE lands on the same edge.
  assign cd_accel  = cd_active ? accel : '0;
  assign all_dq    = &(dq | cd_accel);
  assign all_done  = &(dq | finished | fin_now);
  assign multi_fin = (fin_now & (fin_now - 1'b1)) != '0;

  always_comb begin
    first_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (fin_now[i]) begin
        first_idx = WIN_W'(i);
      end
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    race_player #(
      .POS_W       (POS_W),
      .TRACK_LEN   (TRACK_LEN),
      .SPEED_W     (SPEED_W),
      .MAX_SPEED   (MAX_SPEED),
      .DECAY_TICKS (DECAY_TICKS)
    ) u_player (
      .clk         (clk),
      .rst         (rst),
      .clr         (do_clr),
      .cd_active   (cd_active),
      .race_active (race_active),
      .tick        (tick),
      .accel       (accel[g]),
      .speed       (speed[g*SPEED_W +: SPEED_W]),
      .pos         (pos[g*POS_W +: POS_W]),
      .finished    (finished[g]),
      .dq          (dq[g]),
      .finish_now  (fin_now[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_COUNTDOWN;
      end
      ST_COUNTDOWN: begin
        if (all_dq) state_d = ST_DONE;
        else if (light_step && lights_full) state_d = ST_RACE;
      end
      ST_RACE: begin
        if (all_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) state_d = ST_COUNTDOWN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lights    <= '0;
      light_cnt <= '0;
      go        <= 1'b0;
    end else begin
      go <= state_d == ST_RACE;
      if (do_clr) begin
        lights    <= '0;
        light_cnt <= '0;
      end else if (cd_active && tick) begin
        if (light_step) begin
          light_cnt <= '0;
          lights    <= lights_full ? '0 : ((lights << 1) | NUM_LIGHTS'(1));
        end else begin
          light_cnt <= light_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner_valid <= 1'b0;
      winner_id    <= '0;
      tie          <= 1'b0;
      race_time    <= '0;
    end else if (do_clr) begin
      winner_valid <= 1'b0;
      winner_id    <= '0;
      tie          <= 1'b0;
      race_time    <= '0;
    end else if (race_active) begin
      if (tick && race_time != 16'hFFFF) begin
        race_time <= race_time + 16'd1;
      end
      // Only the first finishing tick decides the result.
      if (!winner_valid && |fin_now) begin
        winner_valid <= 1'b1;
        winner_id    <= first_idx;
        tie          <= multi_fin;
      end
    end
  end

endmodule

// File: tb/tb_race_ctrl.sv
// tb/tb_race_ctrl.sv - directed self-checking bench for race_ctrl
module tb_race_ctrl;

  logic clk = 1'b0;
  logic rst;

  logic        a_tick, a_start, a_abort;
  logic [1:0]  a_accel;
  logic [1:0]  a_state;
  logic [2:0]  a_lights;
  logic        a_go;
  logic [21:0] a_pos;
  logic [7:0]  a_speed;
  logic [1:0]  a_finished, a_dq;
  logic        a_winner_valid, a_tie;
  logic [0:0]  a_winner_id;
  logic [15:0] a_race_time;

  logic        b_tick, b_start, b_abort;
  logic [3:0]  b_accel;
  logic [1:0]  b_state;
  logic [2:0]  b_lights;
  logic        b_go;
  logic [43:0] b_pos;
  logic [15:0] b_speed;
  logic [3:0]  b_finished, b_dq;
  logic        b_winner_valid, b_tie;
  logic [1:0]  b_winner_id;
  logic [15:0] b_race_time;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] cd_lights_exp [8] = '{3'd0, 3'd1, 3'd1, 3'd3, 3'd3, 3'd7, 3'd7, 3'd0};

  always #5 clk = ~clk;

  race_ctrl #(
    .NUM_PLAYERS(2), .POS_W(11), .TRACK_LEN(64), .NUM_LIGHTS(3),
    .LIGHT_TICKS(2), .MAX_SPEED(15), .SPEED_W(4), .DECAY_TICKS(8)
  ) dut_a (
    .clk(clk), .rst(rst), .tick(a_tick), .start(a_start), .abort(a_abort),
    .accel(a_accel), .state(a_state), .lights(a_lights), .go(a_go),
    .pos(a_pos), .speed(a_speed), .finished(a_finished), .dq(a_dq),
    .winner_valid(a_winner_valid), .winner_id(a_winner_id), .tie(a_tie),
    .race_time(a_race_time)
  );

  race_ctrl #(
    .NUM_PLAYERS(4), .POS_W(11), .TRACK_LEN(768), .NUM_LIGHTS(3),
    .LIGHT_TICKS(2), .MAX_SPEED(15), .SPEED_W(4), .DECAY_TICKS(8)
  ) dut_b (
    .clk(clk), .rst(rst), .tick(b_tick), .start(b_start), .abort(b_abort),
    .accel(b_accel), .state(b_state), .lights(b_lights), .go(b_go),
    .pos(b_pos), .speed(b_speed), .finished(b_finished), .dq(b_dq),
    .winner_valid(b_winner_valid), .winner_id(b_winner_id), .tie(b_tie),
    .race_time(b_race_time)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc_a(input logic t, input logic s, input logic ab, input logic [1:0] ac);
    a_tick = t; a_start = s; a_abort = ab; a_accel = ac;
    @(posedge clk); #1;
    a_tick = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_accel = '0;
  endtask

  task automatic cyc_b(input logic t, input logic s, input logic ab, input logic [3:0] ac);
    b_tick = t; b_start = s; b_abort = ab; b_accel = ac;
    @(posedge clk); #1;
    b_tick = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_accel = '0;
  endtask

  initial begin
    rst = 1'b0;
    a_tick = 1'b0; a_start = 1'b0; a_abort = 1'b0; a_accel = '0;
    b_tick = 1'b0; b_start = 1'b0; b_abort = 1'b0; b_accel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", a_state, 0);
    check("rst_lights", a_lights, 0);
    check("rst_go", a_go, 0);
    check("rst_pos", a_pos, 0);
    check("rst_wv", a_winner_valid, 0);
    check("rst_time", a_race_time, 0);
    check("rst_b_state", b_state, 0);
    rst = 1'b1;
    cyc_a(0, 0, 0, 2'b00);

    // countdown lamp sequence then tie race
    cyc_a(0, 1, 0, 2'b00);
    check("cd_enter", a_state, 1);
    for (int i = 0; i < 8; i++) begin
      cyc_a(1, 0, 0, 2'b00);
      check("cd_lights", a_lights, cd_lights_exp[i]);
      check("cd_state", a_state, (i == 7) ? 2 : 1);
      check("cd_go", a_go, (i == 7) ? 1 : 0);
    end
    for (int i = 1; i <= 12; i++) begin
      cyc_a(1, 0, 0, 2'b11);
      if (i == 11) begin
        check("tie_pos11", a_pos, {11'd55, 11'd55});
        check("tie_spd11", a_speed, {4'd11, 4'd11});
        check("tie_fin11", a_finished, 2'b00);
      end
    end
    check("tie_state", a_state, 3);
    check("tie_fin", a_finished, 2'b11);
    check("tie_pos", a_pos, {11'd64, 11'd64});
    check("tie_wv", a_winner_valid, 1);
    check("tie_id", a_winner_id, 0);
    check("tie_flag", a_tie, 1);
    check("tie_time", a_race_time, 12);
    check("tie_go", a_go, 0);
    cyc_a(1, 0, 0, 2'b11);
    check("done_hold_time", a_race_time, 12);
    check("done_hold_state", a_state, 3);

    // false start by player 1
    cyc_a(0, 1, 0, 2'b00);
    check("fs_state", a_state, 1);
    check("fs_clr_wv", a_winner_valid, 0);
    check("fs_clr_pos", a_pos, 0);
    check("fs_clr_time", a_race_time, 0);
    cyc_a(0, 0, 0, 2'b10);
    check("fs_dq", a_dq, 2'b10);
    check("fs_dq_state", a_state, 1);
    for (int i = 0; i < 8; i++) cyc_a(1, 0, 0, 2'b00);
    check("fs_race", a_state, 2);
    for (int i = 0; i < 12; i++) cyc_a(1, 0, 0, 2'b11);
    check("fs_pos", a_pos, {11'd0, 11'd64});
    check("fs_speed", a_speed, {4'd0, 4'd12});
    check("fs_done", a_state, 3);
    check("fs_wv", a_winner_valid, 1);
    check("fs_id", a_winner_id, 0);
    check("fs_tie", a_tie, 0);
    check("fs_dq_hold", a_dq, 2'b10);

    // everyone jumps the start
    cyc_a(0, 1, 0, 2'b00);
    check("adq_clr", a_dq, 2'b00);
    cyc_a(0, 0, 0, 2'b01);
    check("adq_one", a_dq, 2'b01);
    check("adq_one_state", a_state, 1);
    cyc_a(0, 0, 0, 2'b10);
    check("adq_all", a_dq, 2'b11);
    check("adq_state", a_state, 3);
    check("adq_wv", a_winner_valid, 0);

    // four players: saturation, decay, clamp, winner 2
    cyc_b(0, 1, 0, 4'b0000);
    for (int i = 0; i < 8; i++) cyc_b(1, 0, 0, 4'b0000);
    check("b_race", b_state, 2);
    check("b_go", b_go, 1);
    for (int i = 0; i < 20; i++) cyc_b(0, 0, 0, 4'b0100);
    check("b_sat", b_speed, 16'h0F00);
    for (int i = 1; i <= 8; i++) cyc_b(1, 0, 0, 4'b0000);
    check("b_decay", b_speed, 16'h0E00);
    check("b_pos8", b_pos[22 +: 11], 120);
    for (int i = 9; i <= 68; i++) cyc_b(1, 0, 0, 4'b0000);
    check("b_pos68", b_pos[22 +: 11], 764);
    check("b_fin68", b_finished, 4'b0000);
    check("b_wv68", b_winner_valid, 0);
    cyc_b(1, 0, 0, 4'b0000);
    check("b_clamp", b_pos[22 +: 11], 768);
    check("b_fin69", b_finished, 4'b0100);
    check("b_wv", b_winner_valid, 1);
    check("b_id", b_winner_id, 2);
    check("b_tie", b_tie, 0);
    check("b_still_race", b_state, 2);
    check("b_time69", b_race_time, 69);
    for (int i = 0; i < 15; i++) cyc_b(0, 0, 0, 4'b0011);
    check("b_spd01", b_speed, 16'h07FF);
    for (int i = 1; i <= 52; i++) begin
      cyc_b(1, 0, 0, 4'b0011);
      if (i == 51) check("b_pos0_51", b_pos[0 +: 11], 765);
    end
    check("b_fin012", b_finished, 4'b0111);
    check("b_wait3", b_state, 2);
    check("b_id_keep", b_winner_id, 2);
    for (int i = 0; i < 15; i++) cyc_b(0, 0, 0, 4'b1000);
    for (int i = 0; i < 52; i++) cyc_b(1, 0, 0, 4'b1000);
    check("b_done", b_state, 3);
    check("b_fin_all", b_finished, 4'b1111);
    check("b_pos3", b_pos[33 +: 11], 768);
    check("b_id_final", b_winner_id, 2);
    check("b_tie_final", b_tie, 0);
    check("b_time", b_race_time, 173);
    check("b_go_done", b_go, 0);

    // start ignored mid-race, abort beats start, reset mid-race
    cyc_a(0, 1, 0, 2'b00);
    for (int i = 0; i < 8; i++) cyc_a(1, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) cyc_a(1, 0, 0, 2'b11);
    check("ab_pos", a_pos, {11'd3, 11'd3});
    check("ab_time", a_race_time, 3);
    cyc_a(0, 1, 0, 2'b00);
    check("ab_start_ign", a_state, 2);
    check("ab_start_time", a_race_time, 3);
    cyc_a(0, 1, 1, 2'b00);
    check("ab_state", a_state, 0);
    check("ab_pos0", a_pos, 0);
    check("ab_speed0", a_speed, 0);
    check("ab_go", a_go, 0);
    check("ab_lights", a_lights, 0);
    check("ab_time0", a_race_time, 0);
    check("ab_dq", a_dq, 0);
    cyc_a(0, 0, 0, 2'b11);
    check("idle_accel", a_speed, 0);
    cyc_a(0, 1, 0, 2'b00);
    for (int i = 0; i < 8; i++) cyc_a(1, 0, 0, 2'b00);
    for (int i = 0; i < 3; i++) cyc_a(1, 0, 0, 2'b11);
    check("rr_go", a_go, 1);
    rst = 1'b0;
    #2;
    check("rr_state", a_state, 0);
    check("rr_pos", a_pos, 0);
    check("rr_go0", a_go, 0);
    check("rr_time", a_race_time, 0);
    check("rr_speed", a_speed, 0);
    check("rr_b_state", b_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc_a(1, 0, 0, 2'b00);
    check("rr_after", a_state, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
